// File: rtl/axil_mem_arbiter_2to1.sv
// AXI4-Lite 2:1 arbiter in front of a block-memory slave.
// One transaction in flight; round-robin masters, rd/wr alternation.
//
// Ports:
//   s_aclk, s_aresetn      : clock, async active-low reset
//   s0_axi_* / s1_axi_*    : slave ports (0 = PCIe bridge, 1 = local)
//   m_axi_*                : master port to the memory
// All outputs come straight from flops.

module axil_mem_arbiter_2to1 #(
  parameter int MEM_ADDR_BITS = 13,
  parameter int ADDR_W        = 32
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,

  input  logic [ADDR_W-1:0] s0_axi_awaddr,
  input  logic              s0_axi_awvalid,
  output logic              s0_axi_awready,
  input  logic [31:0]       s0_axi_wdata,
  input  logic [3:0]        s0_axi_wstrb,
  input  logic              s0_axi_wvalid,
  output logic              s0_axi_wready,
  output logic [1:0]        s0_axi_bresp,
  output logic              s0_axi_bvalid,
  input  logic              s0_axi_bready,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [31:0]       s0_axi_rdata,
  output logic [1:0]        s0_axi_rresp,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,

  input  logic [ADDR_W-1:0] s1_axi_awaddr,
  input  logic              s1_axi_awvalid,
  output logic              s1_axi_awready,
  input  logic [31:0]       s1_axi_wdata,
  input  logic [3:0]        s1_axi_wstrb,
  input  logic              s1_axi_wvalid,
  output logic              s1_axi_wready,
  output logic [1:0]        s1_axi_bresp,
  output logic              s1_axi_bvalid,
  input  logic              s1_axi_bready,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [31:0]       s1_axi_rdata,
  output logic [1:0]        s1_axi_rresp,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_WAIT,
    WR_RESP,
    RD_ADDR,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [1:0] DECERR = 2'b11;

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [1:0]          last_op_q, last_op_d;
  logic                own_q, own_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          awready_q, awready_d;
  logic [1:0]          wready_q, wready_d;
  logic [1:0]          arready_q, arready_d;
  logic [1:0]          bvalid_q, bvalid_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                m_awvalid_q, m_awvalid_d;
  logic                m_wvalid_q, m_wvalid_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic                m_bready_q, m_bready_d;
  logic                m_rready_q, m_rready_d;

  logic [1:0]          wr_req;
  logic [1:0]          rd_req;
  logic [1:0]          req;
  logic [1:0]          bready;
  logic [1:0]          rready;
  logic                win;
  logic                pick_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [3:0]          sel_wstrb;
  logic                hit;

  assign bready = {s1_axi_bready, s0_axi_bready};
  assign rready = {s1_axi_rready, s0_axi_rready};

  // last_op bit: 1 = write, 0 = read
  always_comb begin
    wr_req = {s1_axi_awvalid & s1_axi_wvalid,
              s0_axi_awvalid & s0_axi_wvalid};
    rd_req = {s1_axi_arvalid, s0_axi_arvalid};
    req    = wr_req | rd_req;
    if (req[0] && req[1]) begin
      win = ~rr_last_q;
    end else begin
      win = req[1];
    end
    if (wr_req[win] && rd_req[win]) begin
      pick_wr = ~last_op_q[win];
    end else begin
      pick_wr = wr_req[win];
    end
    if (pick_wr) begin
      sel_addr = win ? s1_axi_awaddr : s0_axi_awaddr;
    end else begin
      sel_addr = win ? s1_axi_araddr : s0_axi_araddr;
    end
    sel_wdata = win ? s1_axi_wdata : s0_axi_wdata;
    sel_wstrb = win ? s1_axi_wstrb : s0_axi_wstrb;
    // decoded on the value that is latched into addr_q this cycle
    hit = (sel_addr[ADDR_W-1:MEM_ADDR_BITS] == '0);
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    last_op_d   = last_op_q;
    own_d       = own_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awready_d   = '0;
    wready_d    = '0;
    arready_d   = '0;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_arvalid_d = m_arvalid_q;
    m_bready_d  = m_bready_q;
    m_rready_d  = m_rready_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          own_d          = win;
          rr_last_d      = win;
          last_op_d[win] = pick_wr;
          addr_d         = sel_addr;
          if (pick_wr) begin
            wdata_d        = sel_wdata;
            wstrb_d        = sel_wstrb;
            awready_d[win] = 1'b1;
            wready_d[win]  = 1'b1;
            if (hit) begin
              m_awvalid_d = 1'b1;
              m_wvalid_d  = 1'b1;
              state_d     = WR_ADDR;
            end else begin
              bresp_d = DECERR;
              state_d = WR_RESP;
            end
          end else begin
            arready_d[win] = 1'b1;
            if (hit) begin
              m_arvalid_d = 1'b1;
              state_d     = RD_ADDR;
            end else begin
              rresp_d = DECERR;
              rdata_d = '0;
              state_d = RD_RESP;
            end
          end
        end
      end
      WR_ADDR: begin
        // aw and w handshakes retire independently
        if (m_awvalid_q && m_axi_awready) begin
          m_awvalid_d = 1'b0;
        end
        if (m_wvalid_q && m_axi_wready) begin
          m_wvalid_d = 1'b0;
        end
        if (!m_awvalid_d && !m_wvalid_d) begin
          m_bready_d = 1'b1;
          state_d    = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (m_axi_bvalid) begin
          bresp_d    = m_axi_bresp;
          m_bready_d = 1'b0;
          state_d    = WR_RESP;
        end
      end
      WR_RESP: begin
        // valid rises one cycle after entry, so the
        // address/data handshake has always retired first
        if (bvalid_q[own_q] && bready[own_q]) begin
          bvalid_d[own_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          bvalid_d[own_q] = 1'b1;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (m_axi_rvalid) begin
          rdata_d    = m_axi_rdata;
          rresp_d    = m_axi_rresp;
          m_rready_d = 1'b0;
          state_d    = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid_q[own_q] && rready[own_q]) begin
          rvalid_d[own_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          rvalid_d[own_q] = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      last_op_q   <= '0;
      own_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= '0;
      wready_q    <= '0;
      arready_q   <= '0;
      bvalid_q    <= '0;
      rvalid_q    <= '0;
      bresp_q     <= '0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_bready_q  <= 1'b0;
      m_rready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      last_op_q   <= last_op_d;
      own_q       <= own_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_arvalid_q <= m_arvalid_d;
      m_bready_q  <= m_bready_d;
      m_rready_q  <= m_rready_d;
    end
  end

  assign s0_axi_awready = awready_q[0];
  assign s0_axi_wready  = wready_q[0];
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_bvalid  = bvalid_q[0];
  assign s0_axi_arready = arready_q[0];
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign s0_axi_rvalid  = rvalid_q[0];

  assign s1_axi_awready = awready_q[1];
  assign s1_axi_wready  = wready_q[1];
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_bvalid  = bvalid_q[1];
  assign s1_axi_arready = arready_q[1];
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;
  assign s1_axi_rvalid  = rvalid_q[1];

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = m_awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = m_wvalid_q;
  assign m_axi_bready  = m_bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = m_arvalid_q;
  assign m_axi_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_mem_arbiter_2to1.sv
// Directed bench for axil_mem_arbiter_2to1.
// Two AXI4-Lite master drivers plus a behavioural memory slave.

module tb_axil_mem_arbiter_2to1;

  logic clk;
  logic rst_n;

  logic [31:0] s_awaddr [2];
  logic        s_awvalid[2];
  logic        s_awready[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wvalid [2];
  logic        s_wready [2];
  logic [1:0]  s_bresp  [2];
  logic        s_bvalid [2];
  logic        s_bready [2];
  logic [31:0] s_araddr [2];
  logic        s_arvalid[2];
  logic        s_arready[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        s_rvalid [2];
  logic        s_rready [2];

  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  axil_mem_arbiter_2to1 #(
    .MEM_ADDR_BITS(13),
    .ADDR_W(32)
  ) dut (
    .s_aclk(clk),
    .s_aresetn(rst_n),
    .s0_axi_awaddr(s_awaddr[0]),
    .s0_axi_awvalid(s_awvalid[0]),
    .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]),
    .s0_axi_wstrb(s_wstrb[0]),
    .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s_wready[0]),
    .s0_axi_bresp(s_bresp[0]),
    .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]),
    .s0_axi_araddr(s_araddr[0]),
    .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]),
    .s0_axi_rdata(s_rdata[0]),
    .s0_axi_rresp(s_rresp[0]),
    .s0_axi_rvalid(s_rvalid[0]),
    .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]),
    .s1_axi_awvalid(s_awvalid[1]),
    .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]),
    .s1_axi_wstrb(s_wstrb[1]),
    .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s_wready[1]),
    .s1_axi_bresp(s_bresp[1]),
    .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]),
    .s1_axi_araddr(s_araddr[1]),
    .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]),
    .s1_axi_rdata(s_rdata[1]),
    .s1_axi_rresp(s_rresp[1]),
    .s1_axi_rvalid(s_rvalid[1]),
    .s1_axi_rready(s_rready[1]),
    .m_axi_awaddr(m_awaddr),
    .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata),
    .m_axi_wstrb(m_wstrb),
    .m_axi_wvalid(m_wvalid),
    .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp),
    .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr),
    .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata),
    .m_axi_rresp(m_rresp),
    .m_axi_rvalid(m_rvalid),
    .m_axi_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory slave model ----------------
  logic [31:0] mem [0:2047];
  int          aw_stall, w_stall, r_stall;
  int          aw_cnt, w_cnt, r_cnt;
  int          aw_hs, w_hs, ar_hs;
  int          awv_cyc, wv_cyc, arv_cyc;
  logic        aw_got, w_got, ar_pend;
  logic [31:0] aw_q, w_q, ar_q;
  logic [3:0]  ws_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_awready <= 1'b0;
      m_wready  <= 1'b0;
      m_arready <= 1'b0;
      m_bvalid  <= 1'b0;
      m_bresp   <= 2'b00;
      m_rvalid  <= 1'b0;
      m_rresp   <= 2'b00;
      m_rdata   <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      ar_pend   <= 1'b0;
      aw_cnt    <= 0;
      w_cnt     <= 0;
      r_cnt     <= 0;
    end else begin
      m_awready <= 1'b0;
      m_wready  <= 1'b0;
      m_arready <= 1'b0;
      if (m_awvalid && !m_awready && !aw_got) begin
        if (aw_cnt >= aw_stall) m_awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (m_awvalid && m_awready) begin
        aw_got <= 1'b1;
        aw_q   <= m_awaddr;
        aw_hs  <= aw_hs + 1;
        aw_cnt <= 0;
      end
      if (m_wvalid && !m_wready && !w_got) begin
        if (w_cnt >= w_stall) m_wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (m_wvalid && m_wready) begin
        w_got <= 1'b1;
        w_q   <= m_wdata;
        ws_q  <= m_wstrb;
        w_hs  <= w_hs + 1;
        w_cnt <= 0;
      end
      if (aw_got && w_got && !m_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (ws_q[b]) mem[aw_q[12:2]][b*8 +: 8] <= w_q[b*8 +: 8];
        m_bvalid <= 1'b1;
        m_bresp  <= 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && !m_arready && !ar_pend) m_arready <= 1'b1;
      if (m_arvalid && m_arready) begin
        ar_pend <= 1'b1;
        ar_q    <= m_araddr;
        ar_hs   <= ar_hs + 1;
        r_cnt   <= 0;
      end
      if (ar_pend && !m_rvalid) begin
        if (r_cnt >= r_stall) begin
          m_rvalid <= 1'b1;
          m_rdata  <= mem[ar_q[12:2]];
          m_rresp  <= 2'b00;
          ar_pend  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (m_awvalid) awv_cyc <= awv_cyc + 1;
    if (m_wvalid)  wv_cyc  <= wv_cyc + 1;
    if (m_arvalid) arv_cyc <= arv_cyc + 1;
  end

  logic any_out;
  assign any_out = |{s_awready[0], s_wready[0], s_bresp[0],
                     s_bvalid[0], s_arready[0], s_rdata[0],
                     s_rresp[0], s_rvalid[0],
                     s_awready[1], s_wready[1], s_bresp[1],
                     s_bvalid[1], s_arready[1], s_rdata[1],
                     s_rresp[1], s_rvalid[1],
                     m_awaddr, m_awvalid, m_wdata, m_wstrb,
                     m_wvalid, m_bready, m_araddr, m_arvalid,
                     m_rready};

  // ---------------- checking helpers ----------------
  int         vecs;
  int         errs;
  logic [1:0] op_log[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit p, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] st,
                    output logic [1:0] resp);
    logic ok;
    s_awaddr[p]  = a;
    s_wdata[p]   = d;
    s_wstrb[p]   = st;
    s_awvalid[p] = 1'b1;
    s_wvalid[p]  = 1'b1;
    s_bready[p]  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_awready[p]) begin ok = 1'b1; break; end
    end
    chk("wr_grant", 32'(ok & s_wready[p]), 1);
    op_log.push_back({p, 1'b1});
    @(posedge clk); #1;
    s_awvalid[p] = 1'b0;
    s_wvalid[p]  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_bvalid[p]) begin ok = 1'b1; break; end
    end
    chk("wr_bvalid", 32'(ok), 1);
    resp = s_bresp[p];
    @(posedge clk); #1;
    s_bready[p] = 1'b0;
  endtask

  task automatic rd(input bit p, input logic [31:0] a,
                    input int hold,
                    output logic [31:0] d, output logic [1:0] resp);
    logic ok;
    logic stable;
    logic [31:0] d0;
    s_araddr[p]  = a;
    s_arvalid[p] = 1'b1;
    s_rready[p]  = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_arready[p]) begin ok = 1'b1; break; end
    end
    chk("rd_grant", 32'(ok), 1);
    op_log.push_back({p, 1'b0});
    @(posedge clk); #1;
    s_arvalid[p] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_rvalid[p]) begin ok = 1'b1; break; end
    end
    chk("rd_rvalid", 32'(ok), 1);
    if (hold > 0) begin
      d0 = s_rdata[p];
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!s_rvalid[p] || s_rdata[p] !== d0) stable = 1'b0;
      end
      chk("rd_hold_stable", 32'(stable), 1);
      s_rready[p] = 1'b1;
    end
    d    = s_rdata[p];
    resp = s_rresp[p];
    @(posedge clk); #1;
    s_rready[p] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic [31:0] rdv [2];
    logic [31:0] mem0;
    logic        ok;
    int          a0, w0, r0, v0;

    vecs = 0;
    errs = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
    aw_stall = 0; w_stall = 0; r_stall = 0;
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_awvalid[p] = 1'b0;
      s_wdata[p] = '0; s_wstrb[p] = '0; s_wvalid[p] = 1'b0;
      s_bready[p] = 1'b0;
      s_araddr[p] = '0; s_arvalid[p] = 1'b0;
      s_rready[p] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 32'(any_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs_zero", 32'(any_out), 0);
    @(posedge clk); #1;

    // single write then read on s0
    a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
    wr(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, resp);
    chk("t1_bresp", 32'(resp), 0);
    rd(1'b0, 32'h0000_0010, 0, rdat, resp);
    chk("t1_rdata", rdat, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(resp), 0);
    chk("t1_aw_hs", aw_hs - a0, 1);
    chk("t1_w_hs", w_hs - w0, 1);
    chk("t1_ar_hs", ar_hs - r0, 1);

    // both masters write continuously: strict alternation from 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_log.delete();
    fork
      begin : m0
        logic [1:0] r;
        for (int k = 0; k < 4; k++) begin
          wr(1'b0, 32'h0, 32'hA000_0000 + k, 4'hF, r);
          chk("t2_bresp_s0", 32'(r), 0);
        end
      end
      begin : m1
        logic [1:0] r;
        for (int k = 0; k < 4; k++) begin
          wr(1'b1, 32'h4, 32'hB000_0000 + k, 4'hF, r);
          chk("t2_bresp_s1", 32'(r), 0);
        end
      end
    join
    chk("t2_grants", op_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_order%0d", i), 32'(op_log[i]),
          32'((i % 2) * 2 + 1));
    chk("t2_mem_s0", mem[0], 32'hA000_0003);
    chk("t2_mem_s1", mem[1], 32'hB000_0003);

    // s0 rd+wr together, awready stalled 4 cycles
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    aw_stall = 4;
    a0 = aw_hs; w0 = w_hs;
    op_log.delete();
    fork
      begin : mw
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
          wr(1'b0, 32'h20, 32'hC000_0001 + k, 4'hF, r);
          chk("t3_bresp", 32'(r), 0);
        end
      end
      begin : mr
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
          rd(1'b0, 32'h20, 0, rdv[k], r);
          chk("t3_rresp", 32'(r), 0);
        end
      end
    join
    aw_stall = 0;
    chk("t3_ops", op_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), 32'(op_log[i]),
          32'((i % 2 == 0) ? 1 : 0));
    chk("t3_rdata0", rdv[0], 32'hC000_0001);
    chk("t3_rdata1", rdv[1], 32'hC000_0002);
    chk("t3_aw_hs", aw_hs - a0, 2);
    chk("t3_w_hs", w_hs - w0, 2);

    // out-of-window accesses
    v0 = arv_cyc;
    rd(1'b1, 32'h0000_4000, 0, rdat, resp);
    chk("t4_rresp", 32'(resp), 3);
    chk("t4_rdata", rdat, 0);
    chk("t4_no_arvalid", arv_cyc - v0, 0);
    mem0 = mem[0];
    v0 = awv_cyc + wv_cyc;
    wr(1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, resp);
    chk("t4_bresp", 32'(resp), 3);
    chk("t4_no_awvalid", awv_cyc + wv_cyc - v0, 0);
    chk("t4_mem_kept", mem[0], mem0);

    // rready held low 10 cycles
    rd(1'b0, 32'h0000_0010, 10, rdat, resp);
    chk("t5_rdata", rdat, 32'hDEAD_BEEF);
    chk("t5_rresp", 32'(resp), 0);

    // reset while waiting on the memory read
    r_stall = 20;
    s_araddr[0]  = 32'h0000_0010;
    s_arvalid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_arready[0]) begin ok = 1'b1; break; end
    end
    chk("t6_grant", 32'(ok), 1);
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_rready) begin ok = 1'b1; break; end
    end
    chk("t6_rd_wait", 32'(ok), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", 32'(any_out), 0);
    r_stall = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_release_idle", 32'(any_out), 0);
    @(posedge clk); #1;
    rd(1'b0, 32'h0000_0010, 0, rdat, resp);
    chk("t6_rdata", rdat, 32'hDEAD_BEEF);
    chk("t6_rresp", 32'(resp), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
